wb_master_ctrl: RTL and testbench
=================================

WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of BUS-state cycles to wait for ACK_I before aborting.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 2, giving the minimum number of idle cycles between STB_O deassertion and the next STB_O assertion.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLK_I.
REQ-004 Port: CLK_I  in  1  clock.
REQ-005 Port: RST_I  in  1  synchronous active-high reset.
REQ-006 Port: CMD_VALID  in  1  command request.
REQ-007 Port: CMD_READY  out  1  command accepted when CMD_VALID and CMD_READY are both high at a clock edge.
REQ-008 Port: CMD_WE  in  1  1 = write, 0 = read.
REQ-009 Port: CMD_ADDR  in  32  bus address.
REQ-010 Port: CMD_WDATA  in  32  write data.
REQ-011 Port: CMD_SEL  in  4  byte select.
REQ-012 Port: RSP_VALID  out  1  response available.
REQ-013 Port: RSP_READY  in  1  response consumed.
REQ-014 Port: RSP_RDATA  out  32  read data, or 0 on a write or an error.
REQ-015 Port: RSP_ERR  out  1  transaction timed out.
REQ-016 Ports: CYC_O, STB_O, WE_O  out  1 each; SEL_O  out  4; ADR_O  out  32; DAT_O  out  32 -- Wishbone classic master outputs.
REQ-017 Ports: ACK_I  in  1; DAT_I  in  32 -- Wishbone slave acknowledge and read data.

Function
REQ-018 The FSM SHALL have the states IDLE, BUS and RESP; all outputs SHALL be registered.
REQ-019 CMD_READY SHALL equal (state==IDLE && gap_cnt==0).
REQ-020 On command acceptance, the block SHALL latch CMD_WE/ADDR/WDATA/SEL into WE_O/ADR_O/DAT_O/SEL_O, assert CYC_O and STB_O in the next cycle, and enter BUS.
REQ-021 In BUS, CYC_O and STB_O SHALL stay high and WE_O/ADR_O/DAT_O/SEL_O SHALL stay stable until ACK_I is sampled high or a timeout occurs.
REQ-022 When ACK_I is sampled high in BUS: in the next cycle CYC_O=STB_O=0, RSP_RDATA=(WE_O ? 0 : DAT_I as sampled), RSP_ERR=0, RSP_VALID=1, and the state SHALL be RESP.
REQ-023 Timeout counter: cleared on entry to BUS; incremented once per BUS cycle without ACK_I.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES: in the next cycle CYC_O=STB_O=0, RSP_RDATA=0, RSP_ERR=1, RSP_VALID=1, and the state SHALL be RESP.
REQ-025 If ACK_I is high on the timeout cycle, the ACK SHALL win and RSP_ERR SHALL be 0.
REQ-026 RESP SHALL hold RSP_VALID, RSP_RDATA and RSP_ERR stable until RSP_READY is high at an edge, then return to IDLE with RSP_VALID=0.
REQ-027 gap_cnt SHALL load GAP_CYCLES on the edge that leaves BUS and decrement by 1 per cycle to 0 (saturating), independent of state; this prevents a stale delayed ACK from a shifted-acknowledge slave completing the next cycle early.
REQ-028 ACK_I sampled outside BUS SHALL be ignored, with no state or output change.
REQ-029 DAT_O SHALL carry CMD_WDATA on writes and be held at its last value on reads.

Reset
REQ-030 While RST_I is high at an edge, the block SHALL set: state=IDLE, CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, timeout counter=0, gap_cnt=0.
REQ-031 Reset asserted in BUS or RESP SHALL abort the transaction with no response; CMD_READY SHALL be 1 in the first cycle after reset is released.

Verification
REQ-032 Read with slave ACK 2 cycles after STB (wbSlave timing): accept ADDR=0x30000084 at edge 0 -> STB_O high cycles 1-3; ACK seen cycle 3; RSP_VALID=1 and RSP_RDATA=DAT_I value (e.g. 0xDEADBEEF) in cycle 4; STB_O=0 in cycle 4.
REQ-033 Write ADDR=0x30000004, WDATA=0x0000A5A5, SEL=0xF -> WE_O=1 and DAT_O=0x0000A5A5 stable throughout BUS; RSP_ERR=0; RSP_RDATA=0.
REQ-034 Back-to-back commands, CMD_VALID held high, RSP_READY=1 -> at least GAP_CYCLES=2 cycles with STB_O=0 between the two transactions; each transaction receives its own correct data.
REQ-035 Slave never ACKs -> STB_O high for exactly 16 cycles; then RSP_ERR=1 and RSP_RDATA=0; a later normal read succeeds.
REQ-036 ACK_I arrives on the 16th BUS cycle -> RSP_ERR=0 and data latched; RST_I pulsed mid-BUS -> CYC_O=0 next cycle and no RSP_VALID.
REQ-037 RSP_READY held low for 5 cycles -> RSP_VALID and RSP_RDATA stable for all 5 cycles and CMD_READY=0 throughout.

Source files
------------

// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone classic master fed by a command/response handshake.
// Aborts a bus cycle after TIMEOUT_CYCLES without ACK and enforces an idle gap between cycles.
module wb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  input  logic [3:0]  CMD_SEL,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic        ACK_I,
  input  logic [31:0] DAT_I
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;

  logic [TW-1:0] tout_cnt_r;
  logic [TW-1:0] tout_cnt_nxt_s;
  logic [GW-1:0] gap_cnt_r;
  logic [GW-1:0] gap_cnt_nxt_s;

  logic          cmd_ready_r,  cmd_ready_nxt_s;
  logic          cyc_r,        cyc_nxt_s;
  logic          stb_r,        stb_nxt_s;
  logic          we_r,         we_nxt_s;
  logic [3:0]    sel_r,        sel_nxt_s;
  logic [31:0]   adr_r,        adr_nxt_s;
  logic [31:0]   dat_r,        dat_nxt_s;
  logic          rsp_valid_r,  rsp_valid_nxt_s;
  logic [31:0]   rsp_rdata_r,  rsp_rdata_nxt_s;
  logic          rsp_err_r,    rsp_err_nxt_s;

  logic          accept_s;
  logic          bus_ack_s;
  logic          bus_tout_s;

  // ACK outranks the timeout when both land on the same cycle.
  assign accept_s   = (state_r == ST_IDLE) && CMD_VALID && cmd_ready_r;
  assign bus_ack_s  = (state_r == ST_BUS) && ACK_I;
  assign bus_tout_s = (state_r == ST_BUS) && !ACK_I && (tout_cnt_r == TOUT_LAST);

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_BUS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus_ack_s || bus_tout_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BUS;
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs and counters.
  always_comb begin
    cyc_nxt_s       = cyc_r;
    stb_nxt_s       = stb_r;
    we_nxt_s        = we_r;
    sel_nxt_s       = sel_r;
    adr_nxt_s       = adr_r;
    dat_nxt_s       = dat_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    rsp_err_nxt_s   = rsp_err_r;
    tout_cnt_nxt_s  = tout_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cyc_nxt_s      = 1'b1;
          stb_nxt_s      = 1'b1;
          we_nxt_s       = CMD_WE;
          sel_nxt_s      = CMD_SEL;
          adr_nxt_s      = CMD_ADDR;
          tout_cnt_nxt_s = {TW{1'b0}};
          if (CMD_WE) begin
            dat_nxt_s = CMD_WDATA;
          end else begin
            dat_nxt_s = dat_r;
          end
        end else begin
          cyc_nxt_s = 1'b0;
          stb_nxt_s = 1'b0;
        end
      end
      ST_BUS: begin
        if (bus_ack_s) begin
          cyc_nxt_s       = 1'b0;
          stb_nxt_s       = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = 1'b0;
          rsp_rdata_nxt_s = we_r ? 32'h0000_0000 : DAT_I;
        end else if (bus_tout_s) begin
          cyc_nxt_s       = 1'b0;
          stb_nxt_s       = 1'b0;
          rsp_valid_nxt_s = 1'b1;
          rsp_err_nxt_s   = 1'b1;
          rsp_rdata_nxt_s = 32'h0000_0000;
          tout_cnt_nxt_s  = tout_cnt_r + TW'(1);
        end else begin
          tout_cnt_nxt_s  = tout_cnt_r + TW'(1);
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
          rsp_valid_nxt_s = 1'b0;
        end else begin
          rsp_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        cyc_nxt_s       = 1'b0;
        stb_nxt_s       = 1'b0;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase

    // The gap keeps a late ACK from a shifted-acknowledge slave out of the next cycle.
    if ((state_r == ST_BUS) && (state_nxt_s != ST_BUS)) begin
      gap_cnt_nxt_s = GAP_LOAD;
    end else if (gap_cnt_r != {GW{1'b0}}) begin
      gap_cnt_nxt_s = gap_cnt_r - GW'(1);
    end else begin
      gap_cnt_nxt_s = {GW{1'b0}};
    end

    cmd_ready_nxt_s = (state_nxt_s == ST_IDLE) && (gap_cnt_nxt_s == {GW{1'b0}});
  end

  // Output and counter registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cmd_ready_r <= 1'b1;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= 4'h0;
      adr_r       <= 32'h0000_0000;
      dat_r       <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      tout_cnt_r  <= {TW{1'b0}};
      gap_cnt_r   <= {GW{1'b0}};
    end else begin
      cmd_ready_r <= cmd_ready_nxt_s;
      cyc_r       <= cyc_nxt_s;
      stb_r       <= stb_nxt_s;
      we_r        <= we_nxt_s;
      sel_r       <= sel_nxt_s;
      adr_r       <= adr_nxt_s;
      dat_r       <= dat_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      tout_cnt_r  <= tout_cnt_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
    end
  end

  assign CMD_READY = cmd_ready_r;
  assign CYC_O     = cyc_r;
  assign STB_O     = stb_r;
  assign WE_O      = we_r;
  assign SEL_O     = sel_r;
  assign ADR_O     = adr_r;
  assign DAT_O     = dat_r;
  assign RSP_VALID = rsp_valid_r;
  assign RSP_RDATA = rsp_rdata_r;
  assign RSP_ERR   = rsp_err_r;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: directed table, chained and reset sequences, then random
// transactions checked against a transaction-level model of ACK latency and timeout.
module tb_wb_master_ctrl;

  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WE = 1'b0;
  logic [31:0] CMD_ADDR = 32'h0;
  logic [31:0] CMD_WDATA = 32'h0;
  logic [3:0]  CMD_SEL = 4'h0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        CYC_O, STB_O, WE_O;
  logic [3:0]  SEL_O;
  logic [31:0] ADR_O, DAT_O;
  logic        ACK_I = 1'b0;
  logic [31:0] DAT_I = 32'h0;

  wb_master_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WE(CMD_WE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_SEL(CMD_SEL),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .SEL_O(SEL_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .ACK_I(ACK_I), .DAT_I(DAT_I)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          ack_lat;    // BUS cycle carrying ACK_I, 0 = slave never answers
    logic [31:0] sdata;
    int          rsp_delay;  // cycles RSP_READY stays low
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_stb;
  } txn_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_dat = 32'h0;
  int          low_run = 0;
  int          last_gap = -1;
  bit          seen_stb = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: ACK within the timeout window wins, otherwise an error.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    r.exp_err   = (t.ack_lat < 1) || (t.ack_lat > TIMEOUT);
    r.exp_stb   = r.exp_err ? TIMEOUT : t.ack_lat;
    r.exp_rdata = (r.exp_err || t.we) ? 32'h0 : t.sdata;
    return r;
  endfunction

  // Length of the most recent run of STB_O-low cycles between two bus cycles.
  always @(negedge CLK_I) begin
    if (STB_O === 1'b1) begin
      if (seen_stb && low_run > 0) last_gap = low_run;
      seen_stb = 1'b1;
      low_run  = 0;
    end else begin
      low_run++;
    end
  end

  task automatic drive_cmd(input txn_t t);
    CMD_WE = t.we; CMD_ADDR = t.addr; CMD_WDATA = t.wdata; CMD_SEL = t.sel;
  endtask

  // Entered just after a negedge; returns just after a negedge with the response consumed.
  task automatic do_txn(input txn_t t, input bit chain, input txn_t nxt);
    int guard = 0;
    int k = 0;
    bit bad = 1'b0;
    while (CMD_READY !== 1'b1 && guard < 64) begin
      ACK_I = 1'($urandom_range(0, 1)); DAT_I = $urandom;
      @(negedge CLK_I);
      guard++;
    end
    chk("cmd_ready_wait", {31'b0, CMD_READY}, 32'h1);
    drive_cmd(t);
    CMD_VALID = 1'b1;
    ACK_I = 1'b1; DAT_I = $urandom;   // stale ACK in IDLE must be ignored
    if (t.we) exp_dat = t.wdata;
    @(negedge CLK_I);
    if (chain) drive_cmd(nxt);
    else CMD_VALID = 1'b0;
    while (STB_O === 1'b1 && k < 40) begin
      k++;
      if (CYC_O !== 1'b1 || WE_O !== t.we || ADR_O !== t.addr || SEL_O !== t.sel ||
          DAT_O !== exp_dat || CMD_READY !== 1'b0) bad = 1'b1;
      ACK_I = (k == t.ack_lat);
      DAT_I = (k == t.ack_lat) ? t.sdata : $urandom;
      @(negedge CLK_I);
    end
    ACK_I = 1'b0;
    chk("bus_stable", {31'b0, bad}, 32'h0);
    chk("stb_cycles", 32'(k), 32'(t.exp_stb));
    chk("rsp_valid", {31'b0, RSP_VALID}, 32'h1);
    chk("rsp_err", {31'b0, RSP_ERR}, {31'b0, t.exp_err});
    chk("rsp_rdata", RSP_RDATA, t.exp_rdata);
    chk("cyc_low", {31'b0, CYC_O}, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < t.rsp_delay; i++) begin
      RSP_READY = 1'b0;
      ACK_I = 1'b1; DAT_I = $urandom;   // ACK outside BUS must not disturb the response
      @(negedge CLK_I);
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== t.exp_rdata || RSP_ERR !== t.exp_err ||
          CMD_READY !== 1'b0 || STB_O !== 1'b0) bad = 1'b1;
    end
    if (t.rsp_delay > 0) chk("resp_hold", {31'b0, bad}, 32'h0);
    ACK_I = 1'b0;
    RSP_READY = 1'b1;
    @(negedge CLK_I);
    RSP_READY = 1'b0;
    chk("rsp_drop", {31'b0, RSP_VALID}, 32'h0);
  endtask

  txn_t tbl[8];
  txn_t ta, tb, tr;

  initial begin
    tbl[0] = '{we:1'b0, addr:32'h3000_0084, wdata:32'h0, sel:4'hF, ack_lat:3, sdata:32'hDEAD_BEEF,
               rsp_delay:0, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF, exp_stb:3};
    tbl[1] = '{we:1'b1, addr:32'h3000_0004, wdata:32'h0000_A5A5, sel:4'hF, ack_lat:2, sdata:32'h1234_5678,
               rsp_delay:0, exp_err:1'b0, exp_rdata:32'h0, exp_stb:2};
    tbl[2] = '{we:1'b0, addr:32'h3000_0010, wdata:32'h0, sel:4'hF, ack_lat:0, sdata:32'h5A5A_5A5A,
               rsp_delay:1, exp_err:1'b1, exp_rdata:32'h0, exp_stb:16};
    tbl[3] = '{we:1'b0, addr:32'h3000_0020, wdata:32'h0, sel:4'h1, ack_lat:1, sdata:32'hCAFE_F00D,
               rsp_delay:0, exp_err:1'b0, exp_rdata:32'hCAFE_F00D, exp_stb:1};
    tbl[4] = '{we:1'b0, addr:32'h3000_0040, wdata:32'h0, sel:4'hF, ack_lat:16, sdata:32'h600D_DA7A,
               rsp_delay:0, exp_err:1'b0, exp_rdata:32'h600D_DA7A, exp_stb:16};
    tbl[5] = '{we:1'b0, addr:32'h3000_0044, wdata:32'h0, sel:4'hF, ack_lat:17, sdata:32'h7777_7777,
               rsp_delay:0, exp_err:1'b1, exp_rdata:32'h0, exp_stb:16};
    tbl[6] = '{we:1'b0, addr:32'h3000_0048, wdata:32'h0, sel:4'hC, ack_lat:2, sdata:32'h0BAD_C0DE,
               rsp_delay:5, exp_err:1'b0, exp_rdata:32'h0BAD_C0DE, exp_stb:2};
    tbl[7] = '{we:1'b1, addr:32'h3000_0008, wdata:32'h1357_9BDF, sel:4'h3, ack_lat:1, sdata:32'hFFFF_FFFF,
               rsp_delay:2, exp_err:1'b0, exp_rdata:32'h0, exp_stb:1};

    // Reset state.
    repeat (2) @(negedge CLK_I);
    chk("rst_cyc", {31'b0, CYC_O}, 32'h0);
    chk("rst_stb", {31'b0, STB_O}, 32'h0);
    chk("rst_we", {31'b0, WE_O}, 32'h0);
    chk("rst_sel", {28'b0, SEL_O}, 32'h0);
    chk("rst_adr", ADR_O, 32'h0);
    chk("rst_dat", DAT_O, 32'h0);
    chk("rst_rsp_valid", {31'b0, RSP_VALID}, 32'h0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'h0);
    chk("rst_rsp_err", {31'b0, RSP_ERR}, 32'h0);
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("rst_cmd_ready", {31'b0, CMD_READY}, 32'h1);

    for (int i = 0; i < 8; i++) do_txn(tbl[i], 1'b0, tbl[i]);

    // Back-to-back: CMD_VALID held high, response consumed at once.
    ta = model('{we:1'b0, addr:32'h3000_0100, wdata:32'h0, sel:4'hF, ack_lat:2, sdata:32'hA1A1_0001,
                 rsp_delay:0, exp_err:1'b0, exp_rdata:32'h0, exp_stb:0});
    tb = model('{we:1'b0, addr:32'h3000_0104, wdata:32'h0, sel:4'hF, ack_lat:1, sdata:32'hB2B2_0002,
                 rsp_delay:0, exp_err:1'b0, exp_rdata:32'h0, exp_stb:0});
    last_gap = -1;
    do_txn(ta, 1'b1, tb);
    do_txn(tb, 1'b0, tb);
    chk("b2b_gap", 32'(last_gap), 32'(GAP + 1));

    // Reset mid-BUS aborts the write with no response.
    while (CMD_READY !== 1'b1) @(negedge CLK_I);
    tr = model('{we:1'b1, addr:32'h3000_0200, wdata:32'h5555_AAAA, sel:4'hF, ack_lat:0, sdata:32'h0,
                 rsp_delay:0, exp_err:1'b0, exp_rdata:32'h0, exp_stb:0});
    drive_cmd(tr);
    CMD_VALID = 1'b1;
    @(negedge CLK_I);
    CMD_VALID = 1'b0;
    repeat (2) @(negedge CLK_I);
    chk("pre_rst_stb", {31'b0, STB_O}, 32'h1);
    chk("pre_rst_dat", DAT_O, 32'h5555_AAAA);
    RST_I = 1'b1;
    @(negedge CLK_I);
    RST_I = 1'b0;
    exp_dat = 32'h0;
    chk("mid_rst_cyc", {31'b0, CYC_O}, 32'h0);
    chk("mid_rst_stb", {31'b0, STB_O}, 32'h0);
    chk("mid_rst_dat", DAT_O, 32'h0);
    chk("mid_rst_cmd_ready", {31'b0, CMD_READY}, 32'h1);
    begin
      bit bad = 1'b0;
      repeat (3) begin
        @(negedge CLK_I);
        if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) bad = 1'b1;
      end
      chk("mid_rst_no_rsp", {31'b0, bad}, 32'h0);
    end
    do_txn(tbl[0], 1'b0, tbl[0]);

    // Random transactions against the model.
    for (int n = 0; n < 24; n++) begin
      tr.we        = 1'($urandom_range(0, 1));
      tr.addr      = $urandom;
      tr.wdata     = $urandom;
      tr.sel       = 4'($urandom_range(0, 15));
      tr.ack_lat   = $urandom_range(0, TIMEOUT + 2);
      tr.sdata     = $urandom;
      tr.rsp_delay = $urandom_range(0, 3);
      tr = model(tr);
      do_txn(tr, 1'b0, tr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
